// File: rtl/bus_mailbox_port.sv
// Memory-mapped mailbox on the BU2020 bus: CPU-fed TX FIFO, producer-fed RX FIFO, status/mask registers.
// Optional registered interrupt output enabled by defining MAILBOX_IRQ_EN.
module bus_mailbox_port #(
  parameter logic [11:0] BASE_ADDR = 12'hFF0,
  parameter int          DEPTH     = 8,
  parameter int          DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       address_bus,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              write_mode,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_hit,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              irq
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_d [DEPTH];
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] rx_mem_d [DEPTH];
  logic [PTR_W-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PTR_W-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [3:0]        tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

  logic [11:0] offset;
  logic [1:0]  reg_sel;
  logic        in_win;
  logic        wr_tx, wr_rx, wr_status;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_ovf_set, rx_ovf_set;
  logic [2:0]  mask_rd;
  logic [15:0] status;

  assign offset    = address_bus - BASE_ADDR;
  assign in_win    = (offset < 12'd8) && !offset[0];
  assign reg_sel   = offset[2:1];
  assign wr_tx     = write_mode && in_win && (reg_sel == 2'd0);
  assign wr_rx     = write_mode && in_win && (reg_sel == 2'd1);
  assign wr_status = write_mode && in_win && (reg_sel == 2'd2);

  assign tx_full  = (tx_count_q == FULL_CNT);
  assign tx_empty = (tx_count_q == 4'd0);
  assign rx_full  = (rx_count_q == FULL_CNT);
  assign rx_empty = (rx_count_q == 4'd0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem_q[tx_rptr_q];
  assign rx_ready = !rx_full;

  // A push into a full TX FIFO still lands when the consumer drains the head on the same edge.
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && !tx_push;

  // rx_ready comes from state only, so a word offered on the edge that pops a full FIFO is lost
  // without flagging overflow: the FIFO did make room, the producer simply saw ready low.
  assign rx_pop     = wr_rx && !rx_empty;
  assign rx_push    = rx_valid && !rx_full;
  assign rx_ovf_set = rx_valid && rx_full && !rx_pop;

  assign status = {tx_count_q, rx_count_q, 2'b00, rx_ovf_q, tx_ovf_q,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    tx_mem_d   = tx_mem_q;
    rx_mem_d   = rx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    tx_count_d = tx_count_q + 4'(tx_push) - 4'(tx_pop);
    rx_count_d = rx_count_q + 4'(rx_push) - 4'(rx_pop);
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = data_bus;
      tx_wptr_d           = tx_wptr_q + PTR_W'(1);
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + PTR_W'(1);
    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = rx_data;
      rx_wptr_d           = rx_wptr_q + PTR_W'(1);
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + PTR_W'(1);
    // Setting wins over a same-edge write-one-to-clear.
    if (wr_status && data_bus[4]) tx_ovf_d = 1'b0;
    if (wr_status && data_bus[5]) rx_ovf_d = 1'b0;
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_ovf_set) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_count_q <= 4'd0;
      rx_count_q <= 4'd0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

`ifdef MAILBOX_IRQ_EN
  logic       wr_mask;
  logic [2:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  assign wr_mask = write_mode && in_win && (reg_sel == 2'd3);

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = data_bus[2:0];
    irq_d = (mask_q[0] & !rx_empty) | (mask_q[1] & tx_empty) |
            (mask_q[2] & (tx_ovf_q | rx_ovf_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= 3'b000;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = 3'b000;
  assign irq     = 1'b0;
`endif

  assign io_hit = !write_mode && in_win;

  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (reg_sel)
        2'd1:    io_rdata = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
        2'd2:    io_rdata = status;
        2'd3:    io_rdata = {13'b0, mask_rd};
        default: io_rdata = '0;
      endcase
    end
  end

endmodule
